// File: rtl/fare_pkg.sv
// fare_pkg: meter states and default tariff constants shared by the fare_calc slice
package fare_pkg;
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   localparam logic [15:0] DEF_BASE_FARE   = 16'd100;
   localparam logic [15:0] DEF_BASE_KM     = 16'd3;
   localparam logic [15:0] DEF_PER_KM      = 16'd20;
   localparam logic [15:0] DEF_FARE_MAX    = 16'd9999;
   localparam logic [15:0] DEF_WAIT_CYCLES = 16'd10;
   localparam logic [15:0] DEF_WAIT_FARE   = 16'd5;
endpackage

// File: rtl/fare_sat_add.sv
// fare_sat_add: 17-bit fare addition clamped to MAX so the fare never wraps
module fare_sat_add #(
   parameter logic [15:0] MAX = 16'd9999
) (
   input  logic [15:0] a,
   input  logic [15:0] b,
   output logic [15:0] y
);
   logic [16:0] sum;
   always_comb begin
      sum = {1'b0, a} + {1'b0, b};
      y = sum > {1'b0, MAX} ? MAX : sum[15:0];
   end
endmodule

// File: rtl/fare_calc.sv
// fare_calc: taxi meter (IDLE/RUN/DONE), per-km tariff, optional waiting charge under WAIT_FARE_EN
module fare_calc
   import fare_pkg::*;
#(
   parameter logic [15:0] BASE_FARE = DEF_BASE_FARE,
   parameter logic [15:0] BASE_KM   = DEF_BASE_KM,
   parameter logic [15:0] PER_KM    = DEF_PER_KM,
   parameter logic [15:0] FARE_MAX  = DEF_FARE_MAX
`ifdef WAIT_FARE_EN
   ,
   parameter logic [15:0] WAIT_CYCLES = DEF_WAIT_CYCLES,
   parameter logic [15:0] WAIT_FARE   = DEF_WAIT_FARE
`endif
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        work,
   input  logic        start,
   input  logic [15:0] distance,
   output logic [15:0] fare,
   output logic        fare_valid,
   output logic        busy
);
   localparam logic [15:0] BASE_LOAD = BASE_FARE > FARE_MAX ? FARE_MAX : BASE_FARE;
   state_t state, state_nxt;
   logic [15:0] prev_dist, km_cnt, km_nxt, km_fare, fare_nxt;
   logic moved, km_chg;
   assign moved = distance != prev_dist;
   assign km_nxt = &km_cnt ? km_cnt : km_cnt + 16'd1;
   assign km_chg = moved && km_nxt > BASE_KM;
   assign fare_valid = state == DONE;
   assign busy = state == RUN;
   fare_sat_add #(.MAX(FARE_MAX)) u_km_add (
      .a(fare),
      .b(km_chg ? PER_KM : 16'd0),
      .y(km_fare)
   );
`ifdef WAIT_FARE_EN
   logic [15:0] wait_cnt;
   logic wait_hit;
   assign wait_hit = start && wait_cnt == WAIT_CYCLES - 16'd1;
   fare_sat_add #(.MAX(FARE_MAX)) u_wait_add (
      .a(km_fare),
      .b(wait_hit ? WAIT_FARE : 16'd0),
      .y(fare_nxt)
   );
   always_ff @(posedge clk or posedge reset)
      if (reset)
         wait_cnt <= '0;
      else
         wait_cnt <= state == RUN && work && start && !wait_hit ? wait_cnt + 16'd1 : 16'd0;
`else
   assign fare_nxt = km_fare;
`endif
   always_ff @(posedge clk or posedge reset)
      if (reset)
         state <= IDLE;
      else
         state <= state_nxt;
   always_comb begin
      state_nxt = IDLE;
      case (state)
         IDLE: state_nxt = work ? RUN : IDLE;
         RUN:  state_nxt = work ? RUN : DONE;
         DONE: state_nxt = start ? IDLE : DONE;
         default: state_nxt = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         fare <= '0;
         prev_dist <= '0;
         km_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               fare <= work ? BASE_LOAD : 16'd0;
               if (work) begin
                  prev_dist <= distance;
                  km_cnt <= '0;
               end
            end
            RUN: begin
               fare <= fare_nxt;
               if (moved) begin
                  prev_dist <= distance;
                  km_cnt <= km_nxt;
               end
            end
            DONE: if (start) fare <= '0;
            default: fare <= '0;
         endcase
      end
endmodule
